burst_control_unit: RTL and testbench

- Second-generation ARM-pipeline control unit.
- Decodes opcode/funct in Decode (D) and owns the D->E control pipeline register, with stall and flush.
- Adds a burst sequencer: a memory instruction with the PlusOne bit set is expanded into N consecutive word beats for camera pixel streaming.
- Also fixes store/write-enable decoding and replaces undefined ALU codes with NOP plus an illegal flag.

---
 rtl/ctrl_pkg.sv | 55 +++++
 rtl/ctrl_decoder.sv | 78 +++++++
 rtl/burst_control_unit.sv | 169 ++++++++++++++++
 tb/tb_burst_control_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the burst control unit.
//   - opcode, cmd and ALU control encodings
//   - ctrl_e_t : control bundle carried in the D->E pipeline register
//   - burst_state_t : burst sequencer states
//   - sat_burst_len() : clamps a configured burst length to the supported maximum
package ctrl_pkg;

  localparam int CTRL_MAX_BURST = 8;
  localparam int CTRL_BEAT_W    = $clog2(CTRL_MAX_BURST);
  localparam int CTRL_ALUCTL_W  = 4;

  localparam logic [1:0] OPDATA   = 2'b00;
  localparam logic [1:0] OPMEMORY = 2'b01;
  localparam logic [1:0] OPBRANCH = 2'b10;

  localparam logic [3:0] FNOP     = 4'h0;
  localparam logic [3:0] FADD     = 4'h4;
  localparam logic [3:0] FSUB     = 4'h2;
  localparam logic [3:0] FMULT    = 4'h9;
  localparam logic [3:0] FAVERAGE = 4'hA;
  localparam logic [3:0] FPIC     = 4'hF;

  localparam logic [CTRL_ALUCTL_W-1:0] ALU_NOP  = 4'd0;
  localparam logic [CTRL_ALUCTL_W-1:0] ALU_ADD  = 4'd1;
  localparam logic [CTRL_ALUCTL_W-1:0] ALU_SUB  = 4'd2;
  localparam logic [CTRL_ALUCTL_W-1:0] ALU_MULT = 4'd3;
  localparam logic [CTRL_ALUCTL_W-1:0] ALU_AV   = 4'd4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_t;

  typedef struct packed {
    logic                     valid;
    logic                     alusrc;
    logic [CTRL_ALUCTL_W-1:0] aluctl;
    logic                     memtoreg;
    logic                     regwrite;
    logic                     memwrite;
    logic                     branch;
    logic [1:0]               flagw;
    logic [CTRL_BEAT_W-1:0]   beat;
    logic                     illegal;
  } ctrl_e_t;

  // Lengths 0 and 1 both mean a single beat; anything above the maximum clamps.
  function automatic logic [CTRL_BEAT_W:0] sat_burst_len(input logic [CTRL_BEAT_W:0] len);
    if (len > (CTRL_BEAT_W+1)'(CTRL_MAX_BURST))
      sat_burst_len = (CTRL_BEAT_W+1)'(CTRL_MAX_BURST);
    else
      sat_burst_len = len;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Purely combinational instruction decoder for the Decode stage.
// Ports:
//   instr_valid_i : D holds a valid instruction (invalid -> all-zero bundle)
//   opcode_i      : instruction opcode
//   funct_i       : funct field, cmd=[4:1] I=[5] S=[0] P=[4] U=[3] L=[0]
//   ctrl_o        : decoded E-stage bundle (beat index always 0)
//   reg_src_o     : register-source select, independent of valid
//   imm_src_o     : immediate-source select, independent of valid
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int OP_W    = 2
) (
  input  logic               instr_valid_i,
  input  logic [OP_W-1:0]    opcode_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output ctrl_e_t            ctrl_o,
  output logic [1:0]         reg_src_o,
  output logic [1:0]         imm_src_o
);

  logic [3:0] cmd;
  logic       i_bit;
  logic       s_bit;
  logic       u_bit;
  logic       l_bit;
  logic       is_data;
  logic       is_mem;
  logic       is_branch;
  ctrl_e_t    c;

  assign cmd       = funct_i[4:1];
  assign i_bit     = funct_i[5];
  assign s_bit     = funct_i[0];
  assign u_bit     = funct_i[3];
  assign l_bit     = funct_i[0];
  assign is_data   = (opcode_i == OPDATA);
  assign is_mem    = (opcode_i == OPMEMORY);
  assign is_branch = (opcode_i == OPBRANCH);

  assign reg_src_o = {is_mem & ~l_bit, is_branch};
  assign imm_src_o = {is_branch, is_mem};

  always_comb begin
    c = '0;
    if (is_data) begin
      c.alusrc = i_bit;
      case (cmd)
        FNOP:     begin c.aluctl = ALU_NOP;  c.regwrite = 1'b0; end
        FADD:     begin c.aluctl = ALU_ADD;  c.regwrite = 1'b1; end
        FSUB:     begin c.aluctl = ALU_SUB;  c.regwrite = 1'b1; end
        FMULT:    begin c.aluctl = ALU_MULT; c.regwrite = 1'b1; end
        FAVERAGE: begin c.aluctl = ALU_AV;   c.regwrite = 1'b1; end
        // Picture op is handled outside the ALU and writes no register.
        FPIC:     begin c.aluctl = ALU_NOP;  c.regwrite = 1'b0; end
        default:  begin c.aluctl = ALU_NOP;  c.regwrite = 1'b0; c.illegal = 1'b1; end
      endcase
      c.flagw[1] = s_bit;
      c.flagw[0] = s_bit & ((c.aluctl == ALU_ADD) | (c.aluctl == ALU_SUB));
    end else if (is_mem) begin
      c.alusrc   = i_bit;
      c.aluctl   = u_bit ? ALU_SUB : ALU_ADD;
      c.memtoreg = l_bit;
      c.memwrite = ~l_bit;
      c.regwrite = l_bit;
    end else if (is_branch) begin
      c.alusrc   = i_bit;
      c.aluctl   = ALU_ADD;
      c.branch   = 1'b1;
    end else begin
      c.illegal  = 1'b1;
    end
    c.valid = 1'b1;
    ctrl_o  = instr_valid_i ? c : '0;
  end

endmodule

// File: rtl/burst_control_unit.sv
// Control unit: D-stage decode, D->E control register with stall/flush, and a
// burst sequencer that expands a PlusOne memory access into N word beats.
// Optional build macro: CTRL_ILLEGAL_TRAP_EN adds a sticky illegal trap and trap_o.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   instr_valid_d       : D holds a valid instruction
//   opcode_d, funct_d   : instruction fields in D
//   burst_len_i         : beats per PlusOne access (0/1 = single, clamps at MAX_BURST)
//   stall_e_i           : freeze E register and sequencer
//   flush_e_i           : bubble into E, aborts a burst (wins over stall)
//   RegSrcD, ImmSrcD    : combinational D-stage selects
//   StallD              : D must hold its instruction
//   ValidE .. IllegalE  : registered E-stage control
//   trap_o              : sticky illegal trap (only with CTRL_ILLEGAL_TRAP_EN)
module burst_control_unit
  import ctrl_pkg::*;
#(
  parameter int FUNCT_W   = 6,
  parameter int OP_W      = 2,
  parameter int ALUCTL_W  = CTRL_ALUCTL_W,
  parameter int MAX_BURST = CTRL_MAX_BURST,
  parameter int BEAT_W    = $clog2(MAX_BURST)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid_d,
  input  logic [OP_W-1:0]     opcode_d,
  input  logic [FUNCT_W-1:0]  funct_d,
  input  logic [BEAT_W:0]     burst_len_i,
  input  logic                stall_e_i,
  input  logic                flush_e_i,
  output logic [1:0]          RegSrcD,
  output logic [1:0]          ImmSrcD,
  output logic                StallD,
  output logic                ValidE,
  output logic                ALUSrcE,
  output logic [ALUCTL_W-1:0] ALUControlE,
  output logic                MemToRegE,
  output logic                RegWriteE,
  output logic                MemWriteE,
  output logic                BranchE,
  output logic [1:0]          FlagWE,
  output logic [BEAT_W-1:0]   BeatE,
  output logic                IllegalE
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                trap_o
`endif
);

  localparam logic [CTRL_BEAT_W-1:0] BEAT_ONE = CTRL_BEAT_W'(1);
  localparam logic [CTRL_BEAT_W:0]   REM_ONE  = (CTRL_BEAT_W+1)'(1);
  localparam logic [CTRL_BEAT_W:0]   REM_TWO  = (CTRL_BEAT_W+1)'(2);

  ctrl_e_t                dec;
  ctrl_e_t                e_d, e_q;
  ctrl_e_t                lat_d, lat_q;
  burst_state_t           state_d, state_q;
  logic [CTRL_BEAT_W:0]   rem_d, rem_q;
  logic [CTRL_BEAT_W-1:0] beat_d, beat_q;
  logic [CTRL_BEAT_W:0]   n_sat;
  logic                   start;
  logic                   stall_c;

  ctrl_decoder #(
    .FUNCT_W (FUNCT_W),
    .OP_W    (OP_W)
  ) u_dec (
    .instr_valid_i (instr_valid_d),
    .opcode_i      (opcode_d),
    .funct_i       (funct_d),
    .ctrl_o        (dec),
    .reg_src_o     (RegSrcD),
    .imm_src_o     (ImmSrcD)
  );

  assign n_sat = sat_burst_len(burst_len_i);
  assign start = instr_valid_d & (opcode_d == OPMEMORY) & funct_d[4] &
                 (n_sat >= REM_TWO) & ~stall_e_i & ~flush_e_i;

  always_comb begin
    e_d     = e_q;
    lat_d   = lat_q;
    state_d = state_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    stall_c = 1'b0;
    if (flush_e_i) begin
      e_d     = '0;
      state_d = ST_IDLE;
      rem_d   = '0;
      beat_d  = '0;
    end else if (stall_e_i) begin
      stall_c = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          e_d    = dec;
          beat_d = '0;
          if (start) begin
            lat_d   = dec;
            rem_d   = n_sat - REM_ONE;
            state_d = ST_BURST;
            stall_c = 1'b1;
          end
        end
        ST_BURST: begin
          // Replay the latched bundle; D stays frozen until the last beat issues.
          beat_d  = beat_q + BEAT_ONE;
          e_d     = lat_q;
          e_d.beat = beat_q + BEAT_ONE;
          rem_d   = rem_q - REM_ONE;
          stall_c = (rem_q != REM_ONE);
          if (rem_q == REM_ONE) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic trap_d, trap_q;
  assign trap_d = trap_q | (e_d.valid & e_d.illegal);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      e_q     <= '0;
      lat_q   <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      lat_q   <= lat_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  assign StallD      = stall_c & ~reset;
  assign ValidE      = e_q.valid;
  assign ALUSrcE     = e_q.alusrc;
  assign ALUControlE = e_q.aluctl;
  assign MemToRegE   = e_q.memtoreg;
  assign BeatE       = e_q.beat;
  assign IllegalE    = e_q.illegal;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign trap_o    = trap_q;
  assign RegWriteE = e_q.regwrite & ~trap_q;
  assign MemWriteE = e_q.memwrite & ~trap_q;
  assign BranchE   = e_q.branch & ~trap_q;
  assign FlagWE    = e_q.flagw & {2{~trap_q}};
`else
  assign RegWriteE = e_q.regwrite;
  assign MemWriteE = e_q.memwrite;
  assign BranchE   = e_q.branch;
  assign FlagWE    = e_q.flagw;
`endif

endmodule

// File: tb/tb_burst_control_unit.sv
module tb_burst_control_unit;
  import ctrl_pkg::*;

  localparam bit T = 1'b1;
  localparam bit F = 1'b0;

  logic       clk;
  logic       reset;
  logic       instr_valid_d;
  logic [1:0] opcode_d;
  logic [5:0] funct_d;
  logic [3:0] burst_len_i;
  logic       stall_e_i;
  logic       flush_e_i;
  logic [1:0] RegSrcD, ImmSrcD;
  logic       StallD, ValidE, ALUSrcE, MemToRegE, RegWriteE, MemWriteE, BranchE, IllegalE;
  logic [3:0] ALUControlE;
  logic [1:0] FlagWE;
  logic [2:0] BeatE;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       trap_o;
`endif

  int n_total = 0;
  int n_pass  = 0;

  burst_control_unit dut (
    .clk           (clk),
    .reset         (reset),
    .instr_valid_d (instr_valid_d),
    .opcode_d      (opcode_d),
    .funct_d       (funct_d),
    .burst_len_i   (burst_len_i),
    .stall_e_i     (stall_e_i),
    .flush_e_i     (flush_e_i),
    .RegSrcD       (RegSrcD),
    .ImmSrcD       (ImmSrcD),
    .StallD        (StallD),
    .ValidE        (ValidE),
    .ALUSrcE       (ALUSrcE),
    .ALUControlE   (ALUControlE),
    .MemToRegE     (MemToRegE),
    .RegWriteE     (RegWriteE),
    .MemWriteE     (MemWriteE),
    .BranchE       (BranchE),
    .FlagWE        (FlagWE),
    .BeatE         (BeatE),
    .IllegalE      (IllegalE)
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    .trap_o        (trap_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       vld;
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] len;
    logic       e_vld;
    logic [3:0] e_alu;
    logic       e_rw;
    logic       e_mw;
    logic       e_m2r;
    logic       e_br;
    logic [1:0] e_fw;
    logic       e_ill;
    logic       e_src;
    logic [1:0] regsrc;
    logic [1:0] immsrc;
    logic       stalld;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn, input logic [3:0] len);
    instr_valid_d = v;
    opcode_d      = op;
    funct_d       = fn;
    burst_len_i   = len;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(F, OPDATA, 6'b001001, 4'd0);
    stall_e_i = 1'b0;
    flush_e_i = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_bubble(input string nm);
    chk({nm, ".ValidE"},    ValidE,    0);
    chk({nm, ".RegWriteE"}, RegWriteE, 0);
    chk({nm, ".MemWriteE"}, MemWriteE, 0);
    chk({nm, ".MemToRegE"}, MemToRegE, 0);
    chk({nm, ".BranchE"},   BranchE,   0);
    chk({nm, ".FlagWE"},    FlagWE,    0);
  endtask

  initial begin
    // ---------------- reset state ----------------
    reset = 1'b1;
    stall_e_i = 1'b0;
    flush_e_i = 1'b0;
    drive(T, OPDATA, 6'b001001, 4'd0);
    tick();
    tick();
    chk_bubble("reset");
    chk("reset.ALUControlE", ALUControlE, 0);
    chk("reset.BeatE",       BeatE,       0);
    chk("reset.IllegalE",    IllegalE,    0);
    chk("reset.StallD",      StallD,      0);
    reset = 1'b0;

    // ---------------- table-driven single-cycle decode ----------------
    tbl[0]  = '{T, OPDATA,   6'b001001, 4'd0, T, 4'd1, T, F, F, F, 2'b11, F, F, 2'b00, 2'b00, F};
    tbl[1]  = '{T, OPDATA,   6'b100100, 4'd0, T, 4'd2, T, F, F, F, 2'b00, F, T, 2'b00, 2'b00, F};
    tbl[2]  = '{T, OPDATA,   6'b010011, 4'd0, T, 4'd3, T, F, F, F, 2'b10, F, F, 2'b00, 2'b00, F};
    tbl[3]  = '{T, OPDATA,   6'b010100, 4'd0, T, 4'd4, T, F, F, F, 2'b00, F, F, 2'b00, 2'b00, F};
    tbl[4]  = '{T, OPDATA,   6'b000001, 4'd0, T, 4'd0, F, F, F, F, 2'b10, F, F, 2'b00, 2'b00, F};
    tbl[5]  = '{T, OPDATA,   6'b011111, 4'd0, T, 4'd0, F, F, F, F, 2'b10, F, F, 2'b00, 2'b00, F};
    tbl[6]  = '{T, OPMEMORY, 6'b000000, 4'd0, T, 4'd1, F, T, F, F, 2'b00, F, F, 2'b10, 2'b01, F};
    tbl[7]  = '{T, OPMEMORY, 6'b101001, 4'd0, T, 4'd2, T, F, T, F, 2'b00, F, T, 2'b00, 2'b01, F};
    tbl[8]  = '{T, OPBRANCH, 6'b100000, 4'd0, T, 4'd1, F, F, F, T, 2'b00, F, T, 2'b01, 2'b10, F};
    tbl[9]  = '{F, OPDATA,   6'b001001, 4'd0, F, 4'd0, F, F, F, F, 2'b00, F, F, 2'b00, 2'b00, F};
    tbl[10] = '{F, OPMEMORY, 6'b010000, 4'd4, F, 4'd0, F, F, F, F, 2'b00, F, F, 2'b10, 2'b01, F};
    tbl[11] = '{T, OPMEMORY, 6'b010001, 4'd1, T, 4'd1, T, F, T, F, 2'b00, F, F, 2'b00, 2'b01, F};
    tbl[12] = '{T, OPMEMORY, 6'b010000, 4'd0, T, 4'd1, F, T, F, F, 2'b00, F, F, 2'b10, 2'b01, F};
    tbl[13] = '{T, OPDATA,   6'b001110, 4'd0, T, 4'd0, F, F, F, F, 2'b00, T, F, 2'b00, 2'b00, F};
    tbl[14] = '{T, 2'b11,    6'b000000, 4'd0, T, 4'd0, F, F, F, F, 2'b00, T, F, 2'b00, 2'b00, F};

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].vld, tbl[i].op, tbl[i].fn, tbl[i].len);
      #1;
      chk($sformatf("vec%0d.RegSrcD", i), RegSrcD, tbl[i].regsrc);
      chk($sformatf("vec%0d.ImmSrcD", i), ImmSrcD, tbl[i].immsrc);
      chk($sformatf("vec%0d.StallD", i),  StallD,  tbl[i].stalld);
      tick();
      chk($sformatf("vec%0d.ValidE", i),      ValidE,      tbl[i].e_vld);
      chk($sformatf("vec%0d.ALUControlE", i), ALUControlE, tbl[i].e_alu);
      chk($sformatf("vec%0d.RegWriteE", i),   RegWriteE,   tbl[i].e_rw);
      chk($sformatf("vec%0d.MemWriteE", i),   MemWriteE,   tbl[i].e_mw);
      chk($sformatf("vec%0d.MemToRegE", i),   MemToRegE,   tbl[i].e_m2r);
      chk($sformatf("vec%0d.BranchE", i),     BranchE,     tbl[i].e_br);
      chk($sformatf("vec%0d.FlagWE", i),      FlagWE,      tbl[i].e_fw);
      chk($sformatf("vec%0d.IllegalE", i),    IllegalE,    tbl[i].e_ill);
      chk($sformatf("vec%0d.ALUSrcE", i),     ALUSrcE,     tbl[i].e_src);
      chk($sformatf("vec%0d.BeatE", i),       BeatE,       0);
    end

    // ---------------- 4-beat burst, next instruction on cycle 5 ----------------
    do_reset();
    drive(T, OPMEMORY, 6'b010001, 4'd4);
    for (int b = 0; b < 4; b++) begin
      #1;
      chk($sformatf("burst4.StallD%0d", b), StallD, (b != 3));
      tick();
      chk($sformatf("burst4.BeatE%0d", b),     BeatE,     b);
      chk($sformatf("burst4.ValidE%0d", b),    ValidE,    1);
      chk($sformatf("burst4.MemToRegE%0d", b), MemToRegE, 1);
      chk($sformatf("burst4.RegWriteE%0d", b), RegWriteE, 1);
    end
    drive(T, OPDATA, 6'b001001, 4'd4);
    #1;
    chk("burst4.StallD_after", StallD, 0);
    tick();
    chk("burst4.next.ALUControlE", ALUControlE, 1);
    chk("burst4.next.MemToRegE",   MemToRegE,   0);
    chk("burst4.next.BeatE",       BeatE,       0);
    chk("burst4.next.FlagWE",      FlagWE,      2'b11);

    // ---------------- stall at beat 1 for two cycles ----------------
    do_reset();
    drive(T, OPMEMORY, 6'b010001, 4'd4);
    tick();
    chk("stall.BeatE0", BeatE, 0);
    tick();
    chk("stall.BeatE1", BeatE, 1);
    stall_e_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("stall.StallD_hold%0d", k), StallD, 1);
      tick();
      chk($sformatf("stall.BeatE_hold%0d", k), BeatE,  1);
      chk($sformatf("stall.ValidE_hold%0d", k), ValidE, 1);
    end
    stall_e_i = 1'b0;
    #1;
    chk("stall.StallD_b2", StallD, 1);
    tick();
    chk("stall.BeatE2", BeatE, 2);
    #1;
    chk("stall.StallD_b3", StallD, 0);
    tick();
    chk("stall.BeatE3", BeatE, 3);
    chk("stall.ValidE3", ValidE, 1);
    drive(F, OPMEMORY, 6'b010001, 4'd4);
    tick();
    chk("stall.no_extra_beat", ValidE, 0);

    // ---------------- flush (with stall) at beat 2 ----------------
    do_reset();
    drive(T, OPMEMORY, 6'b010001, 4'd4);
    tick();
    tick();
    chk("flush.BeatE1", BeatE, 1);
    flush_e_i = 1'b1;
    stall_e_i = 1'b1;
    #1;
    chk("flush.StallD", StallD, 0);
    tick();
    flush_e_i = 1'b0;
    stall_e_i = 1'b0;
    chk_bubble("flush.e");
    drive(F, OPMEMORY, 6'b010001, 4'd4);
    #1;
    chk("flush.StallD_idle", StallD, 0);
    tick();
    chk("flush.no_beats", ValidE, 0);
    drive(T, OPDATA, 6'b100100, 4'd0);
    tick();
    chk("flush.idle_accepts.ALU", ALUControlE, 2);
    chk("flush.idle_accepts.BeatE", BeatE, 0);

    // ---------------- reset mid-burst ----------------
    do_reset();
    drive(T, OPMEMORY, 6'b010001, 4'd4);
    tick();
    tick();
    chk("rstmid.BeatE1", BeatE, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_bubble("rstmid");
    chk("rstmid.BeatE", BeatE, 0);
    drive(F, OPMEMORY, 6'b010001, 4'd4);
    #1;
    chk("rstmid.StallD", StallD, 0);
    tick();
    chk("rstmid.no_beats", ValidE, 0);

    // ---------------- saturated burst length 15 -> 8 beats ----------------
    do_reset();
    drive(T, OPMEMORY, 6'b011001, 4'd15);
    for (int b = 0; b < 8; b++) begin
      #1;
      chk($sformatf("sat.StallD%0d", b), StallD, (b != 7));
      tick();
      chk($sformatf("sat.BeatE%0d", b), BeatE, b);
      chk($sformatf("sat.ALU%0d", b),   ALUControlE, 2);
    end
    drive(F, OPMEMORY, 6'b011001, 4'd15);
    tick();
    chk("sat.end_bubble", ValidE, 0);

    // ---------------- illegal followed by ADD ----------------
    do_reset();
    drive(T, OPDATA, 6'b001110, 4'd0);
    tick();
    chk("illeg.IllegalE", IllegalE, 1);
    chk("illeg.RegWriteE", RegWriteE, 0);
    drive(T, OPDATA, 6'b001001, 4'd0);
    tick();
    chk("illeg.next.IllegalE", IllegalE, 0);
    chk("illeg.next.ALU", ALUControlE, 1);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("trap.RegWriteE", RegWriteE, 0);
    chk("trap.FlagWE",    FlagWE,    0);
    chk("trap.trap_o",    trap_o,    1);
    do_reset();
    chk("trap.cleared", trap_o, 0);
`else
    chk("notrap.RegWriteE", RegWriteE, 1);
    chk("notrap.FlagWE",    FlagWE,    2'b11);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
